// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding/hazard unit: GPR geometry defaults,
// on/off literals, the x0 address and the hazard-cause bundle.
`ifndef FWD_HAZARD_UNIT_DEFS
`define FWD_HAZARD_UNIT_DEFS
`define GPR_WIDTH 32
`define GPR_ADDR_SPACE 5
`define On 1'b1
`define Off 1'b0
`endif

package fwd_hazard_unit_pkg;

    // x0 is hardwired to zero: never forwarded, never tracked as busy.
    localparam int GPR_X0 = 0;

    typedef struct packed {
        logic lu;
        logic sbh;
        logic wh;
    } hazard_t;

endpackage

// File: rtl/fwd_port_sel.sv
// Single read-port forwarding selector: picks the lowest-indexed (youngest)
// producer stage whose destination matches the operand address.
module fwd_port_sel
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_FWD_SRC = 2,
    parameter int XLEN        = `GPR_WIDTH,
    parameter int AW          = `GPR_ADDR_SPACE
) (
    input  logic [AW-1:0]               i_rs_addr,
    input  logic                        i_rs_re,
    input  logic [NUM_FWD_SRC*AW-1:0]   i_src_rd_addr,
    input  logic [NUM_FWD_SRC-1:0]      i_src_rd_we,
    input  logic [NUM_FWD_SRC*XLEN-1:0] i_src_rd_val,
    output logic                        o_hit,
    output logic [XLEN-1:0]             o_val
);

    localparam logic [AW-1:0] X0 = AW'(GPR_X0);

    logic w_port_live;
    assign w_port_live = i_rs_re && (i_rs_addr != X0);

    // Walk oldest to youngest so the youngest match is the last write.
    always_comb begin
        o_hit = `Off;
        o_val = '0;
        for (int s = NUM_FWD_SRC - 1; s >= 0; s--) begin
            if (w_port_live && i_src_rd_we[s] &&
                (i_src_rd_addr[s*AW +: AW] == i_rs_addr)) begin
                o_hit = `On;
                o_val = i_src_rd_val[s*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use detection and long-latency scoreboard with
// stall accounting; sits between the ID/EXE registers and the EXE operand muxes.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_FWD_SRC  = 2,
    parameter int XLEN         = `GPR_WIDTH,
    parameter int AW           = `GPR_ADDR_SPACE,
    parameter int MAX_STALL    = 64,
    parameter int CNT_W        = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD_PORTS*AW-1:0]   id_rs_addr,
    input  logic [NUM_RD_PORTS-1:0]      id_rs_re,
    input  logic [NUM_RD_PORTS*AW-1:0]   ex_rs_addr,
    input  logic [NUM_RD_PORTS-1:0]      ex_rs_re,
    input  logic [AW-1:0]                ex_rd_addr,
    input  logic                         ex_rd_we,
    input  logic                         ex_is_load,
    input  logic [NUM_FWD_SRC*AW-1:0]    src_rd_addr,
    input  logic [NUM_FWD_SRC-1:0]       src_rd_we,
    input  logic [NUM_FWD_SRC*XLEN-1:0]  src_rd_val,
    input  logic                         lop_issue,
    input  logic [AW-1:0]                lop_rd,
    input  logic                         lop_done,
    input  logic [AW-1:0]                lop_done_rd,
    input  logic                         flush,
    output logic [NUM_RD_PORTS-1:0]      fwd_hit,
    output logic [NUM_RD_PORTS*XLEN-1:0] fwd_val,
    output logic                         stall_id,
    output logic                         bubble_ex,
    output logic [2**AW-1:0]             sb_busy,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic                         stall_timeout
);

    localparam logic [AW-1:0]    X0      = AW'(GPR_X0);
    localparam int               RUN_W   = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

    logic [2**AW-1:0] r_sb_busy;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [RUN_W-1:0] r_run;
    logic             r_timeout;

    hazard_t          w_haz;
    logic             w_stall;
    logic [2**AW-1:0] w_sb_next;
    logic [RUN_W-1:0] w_run_next;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        fwd_port_sel #(
            .NUM_FWD_SRC (NUM_FWD_SRC),
            .XLEN        (XLEN),
            .AW          (AW)
        ) u_sel (
            .i_rs_addr     (ex_rs_addr[p*AW +: AW]),
            .i_rs_re       (ex_rs_re[p]),
            .i_src_rd_addr (src_rd_addr),
            .i_src_rd_we   (src_rd_we),
            .i_src_rd_val  (src_rd_val),
            .o_hit         (fwd_hit[p]),
            .o_val         (fwd_val[p*XLEN +: XLEN])
        );
    end

    always_comb begin
        w_haz = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (id_rs_re[p] && (id_rs_addr[p*AW +: AW] == ex_rd_addr)) begin
                w_haz.lu = `On;
            end
            if (id_rs_re[p] && (id_rs_addr[p*AW +: AW] != X0) &&
                r_sb_busy[id_rs_addr[p*AW +: AW]]) begin
                w_haz.sbh = `On;
            end
        end
        if (!(ex_is_load && ex_rd_we && (ex_rd_addr != X0))) begin
            w_haz.lu = `Off;
        end
        w_haz.wh = lop_issue && (lop_rd != X0) && r_sb_busy[lop_rd];
    end

    assign w_stall   = (|w_haz) && !flush;
    assign stall_id  = w_stall;
    assign bubble_ex = w_stall;

    // Set is applied after clear: the issuing op is younger than the one retiring.
    always_comb begin
        w_sb_next = r_sb_busy;
        if (lop_done) begin
            w_sb_next[lop_done_rd] = `Off;
        end
        if (lop_issue && !w_stall && !flush && (lop_rd != X0)) begin
            w_sb_next[lop_rd] = `On;
        end
        w_sb_next[0] = `Off;
    end

    always_comb begin
        if (!w_stall) begin
            w_run_next = '0;
        end else if (r_run == RUN_MAX) begin
            w_run_next = r_run;
        end else begin
            w_run_next = r_run + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb_busy   <= '0;
            r_stall_cnt <= '0;
            r_run       <= '0;
            r_timeout   <= `Off;
        end else begin
            r_sb_busy <= w_sb_next;
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            r_run     <= w_run_next;
            r_timeout <= (w_run_next == RUN_MAX);
        end
    end

    assign sb_busy       = r_sb_busy;
    assign stall_cnt     = r_stall_cnt;
    assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a rule-level model checked every cycle,
// plus hand-computed literal checks along the directed sequence.
module tb_fwd_hazard_unit;

    localparam int NRP       = 2;
    localparam int NFS       = 2;
    localparam int XLEN      = 32;
    localparam int AW        = 5;
    localparam int NREG      = 1 << AW;
    localparam int MAX_STALL = 16;
    localparam int CNT_W     = 32;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NRP*AW-1:0]    id_rs_addr;
    logic [NRP-1:0]       id_rs_re;
    logic [NRP*AW-1:0]    ex_rs_addr;
    logic [NRP-1:0]       ex_rs_re;
    logic [AW-1:0]        ex_rd_addr;
    logic                 ex_rd_we;
    logic                 ex_is_load;
    logic [NFS*AW-1:0]    src_rd_addr;
    logic [NFS-1:0]       src_rd_we;
    logic [NFS*XLEN-1:0]  src_rd_val;
    logic                 lop_issue;
    logic [AW-1:0]        lop_rd;
    logic                 lop_done;
    logic [AW-1:0]        lop_done_rd;
    logic                 flush;
    logic [NRP-1:0]       fwd_hit;
    logic [NRP*XLEN-1:0]  fwd_val;
    logic                 stall_id;
    logic                 bubble_ex;
    logic [NREG-1:0]      sb_busy;
    logic [CNT_W-1:0]     stall_cnt;
    logic                 stall_timeout;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  chk_en   = 1'b0;

    bit     m_busy [NREG];
    longint m_total;
    int     m_consec;

    fwd_hazard_unit #(
        .NUM_RD_PORTS (NRP),
        .NUM_FWD_SRC  (NFS),
        .XLEN         (XLEN),
        .AW           (AW),
        .MAX_STALL    (MAX_STALL),
        .CNT_W        (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs_addr    (id_rs_addr),
        .id_rs_re      (id_rs_re),
        .ex_rs_addr    (ex_rs_addr),
        .ex_rs_re      (ex_rs_re),
        .ex_rd_addr    (ex_rd_addr),
        .ex_rd_we      (ex_rd_we),
        .ex_is_load    (ex_is_load),
        .src_rd_addr   (src_rd_addr),
        .src_rd_we     (src_rd_we),
        .src_rd_val    (src_rd_val),
        .lop_issue     (lop_issue),
        .lop_rd        (lop_rd),
        .lop_done      (lop_done),
        .lop_done_rd   (lop_done_rd),
        .flush         (flush),
        .fwd_hit       (fwd_hit),
        .fwd_val       (fwd_val),
        .stall_id      (stall_id),
        .bubble_ex     (bubble_ex),
        .sb_busy       (sb_busy),
        .stall_cnt     (stall_cnt),
        .stall_timeout (stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Hazard rules evaluated straight from the current inputs and model busy bits.
    function automatic bit model_stall();
        bit lu = 1'b0;
        bit raw = 1'b0;
        bit waw;
        for (int p = 0; p < NRP; p++) begin
            int a = int'(id_rs_addr[p*AW +: AW]);
            if (id_rs_re[p] && a == int'(ex_rd_addr)) lu = 1'b1;
            if (id_rs_re[p] && a != 0 && m_busy[a]) raw = 1'b1;
        end
        lu  = lu && ex_is_load && ex_rd_we && (ex_rd_addr != 0);
        waw = lop_issue && (lop_rd != 0) && m_busy[lop_rd];
        return (lu || raw || waw) && !flush;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) m_busy[i] <= 1'b0;
            m_total  <= 0;
            m_consec <= 0;
        end else begin
            if (lop_done) m_busy[lop_done_rd] <= 1'b0;
            if (lop_issue && !model_stall() && !flush && lop_rd != 0) m_busy[lop_rd] <= 1'b1;
            m_total  <= m_total + (model_stall() ? 1 : 0);
            m_consec <= model_stall() ? m_consec + 1 : 0;
        end
    end

    always @(negedge clk) begin : cmp
        logic [NRP-1:0]      e_hit;
        logic [NRP*XLEN-1:0] e_val;
        logic [NREG-1:0]     e_busy;
        longint              e_cnt;
        if (chk_en) begin
            e_hit = '0;
            e_val = '0;
            for (int p = 0; p < NRP; p++) begin
                if (ex_rs_re[p] && ex_rs_addr[p*AW +: AW] != 0) begin
                    for (int s = 0; s < NFS; s++) begin
                        if (!e_hit[p] && src_rd_we[s] &&
                            src_rd_addr[s*AW +: AW] == ex_rs_addr[p*AW +: AW]) begin
                            e_hit[p] = 1'b1;
                            e_val[p*XLEN +: XLEN] = src_rd_val[s*XLEN +: XLEN];
                        end
                    end
                end
            end
            for (int i = 0; i < NREG; i++) e_busy[i] = m_busy[i];
            e_cnt = (m_total > CNT_MAX) ? CNT_MAX : m_total;
            chk("m_fwd_hit", 64'(fwd_hit), 64'(e_hit));
            chk("m_fwd_val", 64'(fwd_val), 64'(e_val));
            chk("m_stall_id", 64'(stall_id), 64'(model_stall()));
            chk("m_bubble_ex", 64'(bubble_ex), 64'(model_stall()));
            chk("m_sb_busy", 64'(sb_busy), 64'(e_busy));
            chk("m_stall_cnt", 64'(stall_cnt), 64'(e_cnt));
            chk("m_timeout", 64'(stall_timeout), 64'(m_consec >= MAX_STALL));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_rs_addr  = '0; id_rs_re   = '0;
        ex_rs_addr  = '0; ex_rs_re   = '0;
        ex_rd_addr  = '0; ex_rd_we   = 1'b0; ex_is_load = 1'b0;
        src_rd_addr = '0; src_rd_we  = '0;   src_rd_val = '0;
        lop_issue   = 1'b0; lop_rd   = '0;
        lop_done    = 1'b0; lop_done_rd = '0;
        flush       = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        settle();
        chk("rst_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_busy", 64'(sb_busy), 64'd0);
        chk("rst_timeout", 64'(stall_timeout), 64'd0);
        tick();
        rst = 1'b0;

        // Forwarding priority: youngest source wins.
        ex_rs_addr  = {5'd0, 5'd5}; ex_rs_re = 2'b01;
        src_rd_addr = {5'd5, 5'd5}; src_rd_we = 2'b11;
        src_rd_val  = {32'h0000BBBB, 32'h0000AAAA};
        settle();
        chk("fwd_hit_p0", 64'(fwd_hit[0]), 64'd1);
        chk("fwd_young", 64'(fwd_val[31:0]), 64'h0000AAAA);
        tick();
        src_rd_we = 2'b10;
        settle();
        chk("fwd_old", 64'(fwd_val[31:0]), 64'h0000BBBB);
        tick();
        ex_rs_addr = {5'd6, 5'd5}; ex_rs_re = 2'b11;
        src_rd_addr = {5'd6, 5'd5}; src_rd_we = 2'b11;
        settle();
        chk("fwd_two_ports", 64'(fwd_val), 64'h0000BBBB_0000AAAA);
        tick();
        ex_rs_addr  = '0; ex_rs_re = 2'b11;
        src_rd_addr = '0; src_rd_we = 2'b11;
        src_rd_val  = {32'h00001234, 32'h00001234};
        settle();
        chk("x0_hit", 64'(fwd_hit), 64'd0);
        chk("x0_val", 64'(fwd_val), 64'd0);
        tick();
        idle_inputs();

        // Load-use on port1, then a load to x0 that must not stall.
        ex_is_load = 1'b1; ex_rd_we = 1'b1; ex_rd_addr = 5'd7;
        id_rs_addr = {5'd7, 5'd0}; id_rs_re = 2'b10;
        settle();
        chk("lu_stall", 64'(stall_id), 64'd1);
        chk("lu_bubble", 64'(bubble_ex), 64'd1);
        tick();
        ex_is_load = 1'b0; ex_rd_we = 1'b0;
        settle();
        chk("lu_release", 64'(stall_id), 64'd0);
        chk("lu_cnt", 64'(stall_cnt), 64'd1);
        tick();
        ex_is_load = 1'b1; ex_rd_we = 1'b1; ex_rd_addr = 5'd0;
        id_rs_addr = '0; id_rs_re = 2'b11;
        settle();
        chk("lu_x0", 64'(stall_id), 64'd0);
        tick();
        idle_inputs();

        // Divide to x9 completes 10 cycles after issue.
        lop_issue = 1'b1; lop_rd = 5'd9;
        settle();
        chk("div_issue_nostall", 64'(stall_id), 64'd0);
        tick();
        lop_issue = 1'b0;
        id_rs_addr = {5'd0, 5'd9}; id_rs_re = 2'b01;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                lop_done = 1'b1; lop_done_rd = 5'd9;
            end
            settle();
            if (i == 0) chk("div_busy9", 64'(sb_busy[9]), 64'd1);
            chk("div_stall", 64'(stall_id), 64'd1);
            tick();
        end
        lop_done = 1'b0;
        settle();
        chk("div_release", 64'(stall_id), 64'd0);
        chk("div_cleared", 64'(sb_busy[9]), 64'd0);
        chk("div_cnt", 64'(stall_cnt), 64'd11);
        tick();
        idle_inputs();

        // Same-cycle done and issue to x9: set wins; then WAW on a second issue.
        lop_issue = 1'b1; lop_rd = 5'd9; lop_done = 1'b1; lop_done_rd = 5'd9;
        settle();
        chk("setclr_nostall", 64'(stall_id), 64'd0);
        tick();
        lop_done = 1'b0;
        settle();
        chk("setclr_busy", 64'(sb_busy), 64'h0000_0200);
        chk("waw_stall", 64'(stall_id), 64'd1);
        tick();
        lop_issue = 1'b0;
        settle();
        chk("waw_release", 64'(stall_id), 64'd0);
        tick();

        // Hold a RAW stall on x9 until the run reaches MAX_STALL.
        id_rs_addr = {5'd0, 5'd9}; id_rs_re = 2'b01;
        for (int k = 0; k < MAX_STALL; k++) begin
            settle();
            chk("to_low", 64'(stall_timeout), 64'd0);
            tick();
        end
        settle();
        chk("to_high", 64'(stall_timeout), 64'd1);
        tick();
        flush = 1'b1;
        settle();
        chk("flush_nostall", 64'(stall_id), 64'd0);
        tick();
        flush = 1'b0;
        settle();
        chk("flush_run_reset", 64'(stall_timeout), 64'd0);
        chk("run_cnt", 64'(stall_cnt), 64'd29);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(sb_busy), 64'd0);
        chk("arst_cnt", 64'(stall_cnt), 64'd0);
        chk("arst_timeout", 64'(stall_timeout), 64'd0);
        chk("arst_stall", 64'(stall_id), 64'd0);
        tick();
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        settle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit that replaces the fixed two-source, two-operand forwarding logic.
- Per EXE read port, it picks the youngest matching producer from NUM_FWD_SRC pipeline stages and returns that operand value.
- It detects load-use hazards and keeps a per-GPR scoreboard for long-latency ops (mul/div), stalling ID while a hazard is open.
- It counts stall cycles and flags stall runs that last too long; it sits between ID/EXE pipeline registers and the EXE operand muxes.

Parameters:
- NUM_RD_PORTS, 2, operand read ports per instruction
- NUM_FWD_SRC, 2, forwarding sources; index 0 is youngest (EXE/MEM), highest is oldest (MEM/WB)
- XLEN, `GPR_WIDTH, data width
- AW, `GPR_ADDR_SPACE, GPR address width
- MAX_STALL, 64, consecutive-stall threshold for stall_timeout
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_rs_addr  in  NUM_RD_PORTS*AW  ID-stage source addresses
- id_rs_re  in  NUM_RD_PORTS  ID-stage source read enables
- ex_rs_addr  in  NUM_RD_PORTS*AW  EXE-stage operand addresses
- ex_rs_re  in  NUM_RD_PORTS  EXE-stage operand read enables
- ex_rd_addr  in  AW  destination of instruction in EXE
- ex_rd_we  in  1  EXE instruction writes rd
- ex_is_load  in  1  EXE instruction is a load
- src_rd_addr  in  NUM_FWD_SRC*AW  producer destination per stage
- src_rd_we  in  NUM_FWD_SRC  producer write enable per stage
- src_rd_val  in  NUM_FWD_SRC*XLEN  producer value per stage
- lop_issue  in  1  long-latency op leaving ID this cycle
- lop_rd  in  AW  its destination
- lop_done  in  1  long-latency op writing back
- lop_done_rd  in  AW  its destination
- flush  in  1  pipeline flush
- fwd_hit  out  NUM_RD_PORTS  port p takes fwd_val
- fwd_val  out  NUM_RD_PORTS*XLEN  forwarded operand per port
- stall_id  out  1  hold PC and IF/ID, freeze ID
- bubble_ex  out  1  inject NOP into ID/EXE
- sb_busy  out  2**AW  scoreboard busy bits
- stall_cnt  out  CNT_W  total stalled cycles
- stall_timeout  out  1  consecutive stall run reached MAX_STALL

Behaviour:
- Forwarding (combinational, 0 latency), per port p, independent of other ports:
  - Hit from source s requires ex_rs_re[p], src_rd_we[s], src_rd_addr[s]==ex_rs_addr[p], and ex_rs_addr[p]!=0.
  - Lowest matching s wins. fwd_val[p] = src_rd_val[s].
  - On no hit: fwd_hit[p]=0 and fwd_val[p]=0. No latch inference; every output is assigned on every path.
- Load-use: lu = ex_is_load & ex_rd_we & ex_rd_addr!=0 & any(id_rs_re[p] & id_rs_addr[p]==ex_rd_addr).
- Scoreboard RAW: sbh = any(id_rs_re[p] & id_rs_addr[p]!=0 & sb_busy[id_rs_addr[p]]).
- Scoreboard WAW: wh = lop_issue & lop_rd!=0 & sb_busy[lop_rd].
- stall_id = (lu|sbh|wh) & ~flush. bubble_ex = stall_id.
- Scoreboard update (registered, posedge clk):
  - Set sb_busy[lop_rd] when lop_issue & ~stall_id & ~flush & lop_rd!=0.
  - Clear sb_busy[lop_done_rd] when lop_done.
  - Same register set and cleared in the same cycle: set wins, because the issuing op is younger.
  - Bit 0 is never set.
  - flush does not clear busy bits; in-flight long ops always complete.
- Busy bits are not forwarded: a source whose bit clears at edge k releases ID in cycle k+1.
- stall_cnt: +1 on each cycle with stall_id=1; saturates at all-ones.
- Run counter: +1 per stalled cycle, reset to 0 on any non-stalled cycle, saturates at MAX_STALL. stall_timeout = (run==MAX_STALL), registered.
- Reset (async, rst=1): sb_busy=0, stall_cnt=0, run=0, stall_timeout=0. Combinational outputs follow inputs; with scoreboard clear, stall_id depends on lu only.
- Reset mid-operation: all pending busy bits are dropped; the pipeline is reset alongside.

Decomposition:
- Shared package/defines: `GPR_WIDTH, `GPR_ADDR_SPACE, `On/`Off, and the x0 address constant.
- One sub-module, fwd_port_sel: single-port priority selector over NUM_FWD_SRC sources, instantiated NUM_RD_PORTS times with a generate loop.
- The scoreboard and counters live in the top module.

Test Plan:
- Port0 reads x5; src0 and src1 both write x5 with 0xAAAA and 0xBBBB -> fwd_hit[0]=1, fwd_val[0]=0xAAAA. With src0_we=0 -> 0xBBBB.
- Both ports read x0; both sources write x0 with 0x1234 -> fwd_hit=00, fwd_val=0.
- EXE holds a load to x7; ID reads x7 on port1 -> stall_id=1 and bubble_ex=1 for exactly one cycle; stall_cnt increments by 1.
- Div issues to x9; lop_done arrives 10 cycles later; ID reads x9 meanwhile -> stall_id held high for 10 cycles, release in the next cycle, sb_busy[9] cleared.
- lop_done for x9 and a new lop_issue to x9 in the same cycle with scoreboard clear -> sb_busy[9]=1 afterwards. Second issue to x9 while busy -> stall (WAW).
- Hold stall for MAX_STALL cycles -> stall_timeout=1. Assert rst mid-run -> sb_busy=0, stall_cnt=0, stall_timeout=0 immediately (asynchronously).
